// File: rtl/i2s_pkg.sv
// Shared defaults and frame-position constants for the I2S transmit path.
package i2s_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int SLOT_W_DEF   = 32;
  localparam int BCLK_DIV_DEF = 4;

  localparam int FRAME_CLKS    = 2 * SLOT_W_DEF * BCLK_DIV_DEF;
  localparam int MSB_POS       = 1;
  localparam int LAST_DATA_POS = DATA_W_DEF;

  function automatic int frame_clks(input int slot_w, input int bclk_div);
    return 2 * slot_w * bclk_div;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// Bit-clock and word-select generator: div/bit counters, registered bclk/lr_clk,
// falling-edge and frame-load strobes that mark the edge about to happen.
module i2s_clkgen import i2s_pkg::*; #(
  parameter  int SLOT_W   = SLOT_W_DEF,
  parameter  int BCLK_DIV = BCLK_DIV_DEF,
  localparam int DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1,
  localparam int BIT_W    = $clog2(2 * SLOT_W)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             bclk,
  output logic             lr_clk,
  output logic             bclk_fall,
  output logic             frame_load,
  output logic [BIT_W-1:0] bit_idx
);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF    = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] RIGHT_FIRST = BIT_W'(SLOT_W);

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;

  assign bclk_fall  = (div_q == DIV_LAST);
  assign frame_load = bclk_fall && (bit_q == BIT_LAST);
  assign bit_idx    = bit_q;

  always_comb begin
    div_d = bclk_fall ? '0 : div_q + 1'b1;
    bit_d = bit_q;
    if (bclk_fall) bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
  end

  // bclk/lr_clk are computed from the next counter values so they stay registered
  // yet always equal the decode of the current counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      bit_q  <= '0;
      bclk   <= 1'b0;
      lr_clk <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      bclk   <= (div_d >= DIV_HALF);
      lr_clk <= (bit_d >= RIGHT_FIRST);
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S master transmitter: one-sample holding buffer, frame register and MSB-first shifter.
// Build option I2S_TX_HOLD_EN: on underrun retransmit the previous sample instead of zeros.
module i2s_tx_serializer import i2s_pkg::*; #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int SLOT_W   = SLOT_W_DEF,
  parameter int BCLK_DIV = BCLK_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lr_clk,
  output logic              sdata,
  output logic              underrun
);

  localparam int BIT_W = $clog2(2 * SLOT_W);
  localparam logic [BIT_W-1:0] LEFT_LAST = BIT_W'(SLOT_W - 1);

  logic              bclk_fall, frame_load;
  logic [BIT_W-1:0]  bit_idx;
  logic              accept, buf_full, no_sample;
  logic [DATA_W-1:0] buf_q, frame_q, frame_d, shift_q;

  i2s_clkgen #(.SLOT_W(SLOT_W), .BCLK_DIV(BCLK_DIV)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .bclk       (bclk),
    .lr_clk     (lr_clk),
    .bclk_fall  (bclk_fall),
    .frame_load (frame_load),
    .bit_idx    (bit_idx)
  );

  // in_ready doubles as the buffer-empty flag.
  assign buf_full  = !in_ready;
  assign accept    = in_valid && in_ready;
  assign no_sample = frame_load && !accept && !buf_full;

  always_comb begin
    frame_d = frame_q;
    if (frame_load) begin
      if (accept)        frame_d = in_data;
      else if (buf_full) frame_d = buf_q;
      else begin
`ifdef I2S_TX_HOLD_EN
        frame_d = frame_q;
`else
        frame_d = '0;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b1;
      buf_q    <= '0;
      frame_q  <= '0;
      underrun <= 1'b0;
    end else begin
      frame_q  <= frame_d;
      underrun <= no_sample;
      if (frame_load && buf_full) begin
        in_ready <= 1'b1;
      end else if (accept && !frame_load) begin
        buf_q    <= in_data;
        in_ready <= 1'b0;
      end
    end
  end

  // Slot position 0 is always 0; the shifter is reloaded there and zeros shift in
  // behind the data, so positions past DATA_W fall out as 0 without a compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      sdata   <= 1'b0;
    end else if (bclk_fall) begin
      if (frame_load) begin
        shift_q <= frame_d;
        sdata   <= 1'b0;
      end else if (bit_idx == LEFT_LAST) begin
        shift_q <= frame_q;
        sdata   <= 1'b0;
      end else begin
        sdata   <= shift_q[DATA_W-1];
        shift_q <= shift_q << 1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: frame scoreboard plus directed handshake, bypass, reset and period checks.
module tb_i2s_tx_serializer;
  import i2s_pkg::*;

  localparam int DW  = DATA_W_DEF;
  localparam int SW  = SLOT_W_DEF;
  localparam int DIV = BCLK_DIV_DEF;
`ifdef I2S_TX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, bclk, lr_clk, sdata, underrun;

  int total = 0, bad = 0;
  int cyc = 0, tick = 0, pos = 0;
  int urun_cnt = 0, frames_done = 0;
  int bper_bad = 0, lper_bad = 0, lmeas = 0, ledge_bad = 0, lpos_bad = 0;
  int last_b = -1, last_l = -1;
  logic pb = 1'b0, pl = 1'b0;
  logic [2*SW-1:0] fr = '0;
  logic [DW-1:0] sb_q[$];

  i2s_tx_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bclk     (bclk),
    .lr_clk   (lr_clk),
    .sdata    (sdata),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Reference cycle count since reset release; a frame starts when cyc % FRAME_CLKS == 0.
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    @(negedge clk);
    while (cyc < n && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_cyc", cyc, n);
  endtask

  task automatic send(input logic [DW-1:0] d);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", in_ready, 1);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Frame monitor: samples sdata on bclk rising edges, rebuilds each frame and
  // compares it to the scoreboard head; also tracks clock periods and underruns.
  always @(negedge clk) begin : mon
    logic [DW-1:0] l, r;
    logic          pad;
    tick++;
    if (rst) begin
      pos    = 0;
      last_b = -1;
      last_l = -1;
    end else begin
      if (lr_clk !== pl && !(pb && !bclk)) ledge_bad++;
      if (lr_clk && !pl) begin
        if (last_l >= 0) begin
          lmeas++;
          if (tick - last_l != FRAME_CLKS) lper_bad++;
        end
        last_l = tick;
      end
      if (bclk && !pb) begin
        if (last_b >= 0 && tick - last_b != DIV) bper_bad++;
        last_b = tick;
        if (lr_clk !== (pos >= SW)) lpos_bad++;
        fr[pos] = sdata;
        pos++;
        if (pos == 2 * SW) begin
          l = '0; r = '0; pad = 1'b0;
          for (int i = 0; i < SW; i++) begin
            if (i >= MSB_POS && i <= LAST_DATA_POS) begin
              l = {l[DW-2:0], fr[i]};
              r = {r[DW-2:0], fr[SW+i]};
            end else begin
              pad = pad | fr[i] | fr[SW+i];
            end
          end
          chk("sb_nonempty", (sb_q.size() != 0), 1);
          if (sb_q.size() != 0) begin
            logic [DW-1:0] exp;
            exp = sb_q.pop_front();
            chk("left", l, exp);
            chk("right", r, exp);
            chk("pad_zero", pad, 0);
          end
          frames_done++;
          pos = 0;
        end
      end
      if (underrun) urun_cnt++;
    end
    pb = bclk;
    pl = lr_clk;
  end

  initial begin
    int            acc = 0, gap_bad = 0, last_acc = -1, stuck = 0, guard = 0;
    logic          prev_rdy = 1'b0, lr_seen = 1'b0;
    logic [DW-1:0] cnt = 24'h000100;

    repeat (3) @(negedge clk);
    chk("rst_bclk", bclk, 0);
    chk("rst_lr", lr_clk, 0);
    chk("rst_sdata", sdata, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
    sb_q.push_back('0);                 // first frame after reset is silent
    rst = 1'b0;

    // Basic sample ahead of the first load event.
    send(24'hA5F00F);
    sb_q.push_back(24'hA5F00F);
    chk("ready_fall", in_ready, 0);
    wait_cyc(300);
    chk("urun_after_load0", urun_cnt, 0);

    // Nothing offered for frame 2: underrun at the second load event.
    sb_q.push_back(HOLD ? 24'hA5F00F : 24'h000000);
    wait_cyc(520);
    chk("urun_pulse", urun_cnt, 1);

    // Free-running source with in_valid held high for three frames.
    wait_cyc(600);
    in_data  = cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
      if (in_ready && prev_rdy) stuck++;
      prev_rdy = in_ready;
      if (in_ready) begin
        sb_q.push_back(in_data);
        if (acc >= 2 && cyc - last_acc != FRAME_CLKS) gap_bad++;
        last_acc = cyc;
        acc++;
      end
      @(posedge clk);
      #1;
      cnt++;
      in_data = cnt;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("stream_accepts", acc, 4);
    chk("stream_gap", gap_bad, 0);
    chk("stream_ready_stuck", stuck, 0);

    // Bypass: offer only in the load-event cycle of frame 6 -> 7.
    wait_cyc(7 * FRAME_CLKS - 1);
    chk("bypass_ready_pre", in_ready, 1);
    in_data  = 24'h800001;
    in_valid = 1'b1;
    sb_q.push_back(24'h800001);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bypass_ready_post", in_ready, 1);
    wait_cyc(7 * FRAME_CLKS + 8);
    chk("bypass_urun", urun_cnt, 1);

    // Reset at bit 40 of frame 8 with the buffer holding a sample.
    wait_cyc(8 * FRAME_CLKS + 12);
    send(24'h123456);
    chk("buf_full", in_ready, 0);
    wait_cyc(8 * FRAME_CLKS + 40 * DIV + 1);
    chk("pre_rst_lr", lr_clk, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_bclk", bclk, 0);
    chk("mid_rst_lr", lr_clk, 0);
    chk("mid_rst_sdata", sdata, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_underrun", underrun, 0);
    sb_q.push_back('0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    guard = 0;
    while (cyc < SW * DIV && guard < 1000) begin
      if (lr_clk) lr_seen = 1'b1;
      @(negedge clk);
      guard++;
    end
    chk("post_rst_left_slot", lr_seen, 0);
    chk("post_rst_right_slot", lr_clk, 1);

    guard = 0;
    while (sb_q.size() != 0 && guard < 2 * FRAME_CLKS) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drained", sb_q.size(), 0);
    chk("frames_done", frames_done, 9);
    chk("bclk_period", bper_bad, 0);
    chk("lr_period", lper_bad, 0);
    chk("lr_measured", (lmeas > 0), 1);
    chk("lr_on_bclk_fall", ledge_bad, 0);
    chk("lr_slot_pos", lpos_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Serializes 24-bit decimated PCM samples onto a standard I2S link, generating the bit clock and word-select (lr_clk) from the system clock. Sits downstream of the comb/differentiator output at the link end. It is the master of the lr_clk framing that the decimation chain consumes. A single-entry holding buffer with a valid/ready handshake decouples the filter's sample production from the frame timing.

## Interface
- DATA_W, 24, sample width; must satisfy DATA_W <= SLOT_W-1
- SLOT_W, 32, bclk periods per channel slot
- BCLK_DIV, 4, clk cycles per bclk period; even, >= 2
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high (clock clk)
- in_data  in  DATA_W  sample, two's complement
- in_valid  in  1  in_data valid
- in_ready  out  1  holding buffer empty
- bclk  out  1  I2S bit clock
- lr_clk  out  1  word select; 0 = left slot, 1 = right slot
- sdata  out  1  serial data, MSB first
- underrun  out  1  one-clk pulse when a frame starts with no sample available

## Operation
- Reset values: bclk 0, lr_clk 0, sdata 0, in_ready 1, underrun 0. Counters, buffer and shifter are cleared.
- div counter runs 0..BCLK_DIV-1. bclk is 1 when div >= BCLK_DIV/2.
- A bclk falling edge is the clk edge where div wraps from BCLK_DIV-1 to 0.
- bit counter runs 0..2*SLOT_W-1 and advances on each bclk falling edge.
- lr_clk = (bit >= SLOT_W).
- Frame load event: div == BCLK_DIV-1 and bit == 2*SLOT_W-1. On this event the holding buffer moves to the frame register.
  - If the buffer is empty, underrun pulses and a zero sample is used.
  - If in_valid && in_ready occur in the same cycle as the load event, in_data bypasses the buffer straight into the frame register. No underrun is raised in that case.
- Handshake: a sample is accepted when in_valid && in_ready. in_ready falls the next cycle. in_ready returns to 1 the cycle after the buffer empties at a load event.
- Slot bit positions: in both slots, position 0 drives 0, because lr_clk leads data by one bclk. Positions 1..DATA_W drive frame-register bits DATA_W-1..0. Remaining positions drive 0.
- Mono link: the right slot carries the same sample as the left slot.
- The first frame after reset transmits zeros and does not raise underrun.

## Timing
- All outputs are registered. bclk, lr_clk and sdata all change on bclk falling edges, so sdata and lr_clk are stable at bclk rising edges.
- Frame length is 2*SLOT_W*BCLK_DIV clk cycles; this is 256 at the defaults.
- Latency: a sample accepted before load event N has its MSB on sdata starting at bit 1 of the frame that follows event N, i.e. BCLK_DIV clk cycles after that frame begins.
- Reset asserted mid-frame: outputs go to their reset values immediately and any buffered sample is discarded. After release the block restarts at div 0, bit 0.

## Configuration
- I2S_TX_HOLD_EN
  - Defined: on underrun the frame register keeps its previous sample, which is retransmitted. underrun still pulses.
  - Undefined: on underrun zeros are transmitted.

## Structure
- Package i2s_pkg holds:
  - the DATA_W and SLOT_W defaults;
  - the frame-length constant FRAME_CLKS = 2*SLOT_W*BCLK_DIV;
  - the bit-position constants MSB_POS = 1 and LAST_DATA_POS = DATA_W.
- Sub-module i2s_clkgen owns the div and bit counters. It produces bclk, lr_clk, a bclk falling-edge strobe, the slot bit index and the frame load strobe.
- The top level owns the holding buffer, the frame register, the shifter and the underrun logic.

## Test plan
- Defaults; send 0xA5F00F before the first load event. In both slots, bits 1..24 read MSB first equal 0xA5F00F, bits 0 and 25..31 are 0, and underrun stays 0.
- No sample offered for one frame, with I2S_TX_HOLD_EN undefined: underrun pulses for exactly 1 clk at the load event and both slots are all zeros. With the macro defined, the previous sample repeats.
- in_valid held high from a free-running sample counter: exactly one sample is accepted per 256 clk, in_ready deasserts between accepts, and no sample is lost or duplicated.
- in_valid asserted only in the load-event cycle with 0x800001: the sample bypasses the buffer, it is transmitted in the next frame, and underrun stays 0.
- Assert rst at bit 40 of a frame with the buffer full: all outputs return to reset values at once. After release, lr_clk stays 0 for 32 bclk periods and the first frame is zeros.
- Periods: measure bclk period = 4 clk and lr_clk period = 256 clk. lr_clk toggles only on bclk falling edges.
